// File: rtl/dram_refresh_arbiter_pkg.sv
// Shared definitions for the DRAM refresh arbiter and the DRAM controller:
// arbiter state encoding and default refresh timing constants.
package dram_refresh_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCpu,
    StCpuEnd,
    StRef
  } arb_state_e;

  // 15.6 us refresh period at 25 MHz
  localparam int unsigned DefRefInterval = 390;
  localparam int unsigned DefMaxCredits  = 4;
  localparam int unsigned CreditW        = 3;

endpackage

// File: rtl/refresh_timer.sv
// Refresh interval counter: counts down from Interval-1 to 0 and reloads,
// producing a one-cycle tick while the count is zero.
module refresh_timer
  import dram_refresh_arbiter_pkg::*;
#(
  parameter int unsigned Interval = DefRefInterval
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int unsigned CntW = (Interval > 1) ? $clog2(Interval) : 1;
  localparam logic [CntW-1:0] Reload = CntW'(Interval - 1);

  logic [CntW-1:0] count_q, count_d;

  always_comb begin
    tick_o  = (count_q == '0);
    count_d = tick_o ? Reload : count_q - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= Reload;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dram_refresh_arbiter.sv
// Arbitrates the DRAM between CPU accesses and CAS-before-RAS refresh, tracking
// owed refreshes as saturating credits with a sticky overrun flag.
module dram_refresh_arbiter
  import dram_refresh_arbiter_pkg::*;
#(
  parameter int unsigned REF_INTERVAL = DefRefInterval,
  parameter int unsigned MAX_CREDITS  = DefMaxCredits
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               CS_n,
  input  logic               AS_n,
  input  logic               ACC_DONE,
  input  logic               REF_DONE,
  output logic               GRANT_CPU,
  output logic               GRANT_REF,
  output logic [CreditW-1:0] REF_PENDING,
  output logic               REF_OVERRUN
);

  localparam logic [CreditW-1:0] MaxCred = CreditW'(MAX_CREDITS);

  logic cs_s1_q, cs_s2_q, as_s1_q, as_s2_q;
  logic cpu_req_q;
  logic tick, ref_dec;
  logic [CreditW-1:0] credits_q, credits_d;
  logic overrun_q, overrun_d;
  logic grant_cpu_q, grant_ref_q;
  arb_state_e state_q, state_d;

  // cpu_req is registered once more after the synchronizers, so a strobe
  // sampled at edge k reaches the grant at edge k+3.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      as_s1_q   <= 1'b1;
      as_s2_q   <= 1'b1;
      cpu_req_q <= 1'b0;
    end else begin
      cs_s1_q   <= CS_n;
      cs_s2_q   <= cs_s1_q;
      as_s1_q   <= AS_n;
      as_s2_q   <= as_s1_q;
      cpu_req_q <= ~cs_s2_q & ~as_s2_q;
    end
  end

  refresh_timer #(
    .Interval(REF_INTERVAL)
  ) u_refresh_timer (
    .clk_i (CLK),
    .rst_ni(RST_n),
    .tick_o(tick)
  );

  // A tick and a completed refresh in the same cycle cancel out.
  always_comb begin
    ref_dec   = REF_DONE && (state_q == StRef);
    credits_d = credits_q;
    overrun_d = overrun_q;
    if (tick && !ref_dec) begin
      if (credits_q == MaxCred) begin
        overrun_d = 1'b1;
      end else begin
        credits_d = credits_q + CreditW'(1);
      end
    end else if (!tick && ref_dec && (credits_q != '0)) begin
      credits_d = credits_q - CreditW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (credits_q == MaxCred) begin
          state_d = StRef;
        end else if (cpu_req_q) begin
          state_d = StCpu;
        end else if (credits_q != '0) begin
          state_d = StRef;
        end
      end
      StCpu: begin
        if (ACC_DONE) state_d = StCpuEnd;
      end
      // Wait for the strobe to be released so it is never granted twice.
      StCpuEnd: begin
        if (as_s2_q) state_d = StIdle;
      end
      StRef: begin
        if (REF_DONE) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= StIdle;
      credits_q   <= '0;
      overrun_q   <= 1'b0;
      grant_cpu_q <= 1'b0;
      grant_ref_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      credits_q   <= credits_d;
      overrun_q   <= overrun_d;
      grant_cpu_q <= (state_d == StCpu);
      grant_ref_q <= (state_d == StRef);
    end
  end

  assign GRANT_CPU   = grant_cpu_q;
  assign GRANT_REF   = grant_ref_q;
  assign REF_PENDING = credits_q;
  assign REF_OVERRUN = overrun_q;

endmodule

// File: tb/tb_dram_refresh_arbiter.sv
// Directed bench for dram_refresh_arbiter with REF_INTERVAL=8, MAX_CREDITS=4.
module tb_dram_refresh_arbiter;

  logic       CLK, RST_n, CS_n, AS_n, ACC_DONE, REF_DONE;
  logic       GRANT_CPU, GRANT_REF, REF_OVERRUN;
  logic [2:0] REF_PENDING;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  typedef struct {
    logic       cs_n, as_n, acc, rdone;
    logic       gc, gr;
    logic [2:0] pend;
    logic       ovr;
  } vec_t;

  vec_t tbl[$];

  dram_refresh_arbiter #(
    .REF_INTERVAL(8),
    .MAX_CREDITS (4)
  ) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .CS_n       (CS_n),
    .AS_n       (AS_n),
    .ACC_DONE   (ACC_DONE),
    .REF_DONE   (REF_DONE),
    .GRANT_CPU  (GRANT_CPU),
    .GRANT_REF  (GRANT_REF),
    .REF_PENDING(REF_PENDING),
    .REF_OVERRUN(REF_OVERRUN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (RST_n === 1'b1 && ((GRANT_CPU && GRANT_REF) || REF_PENDING > 3'd4)) begin
      miscompares++;
      $display("FAIL invariant @cycle %0d: cpu=%b ref=%b pend=%0d", cycle, GRANT_CPU,
               GRANT_REF, REF_PENDING);
    end
  end

  task automatic chk(input string name, input logic gc, input logic gr,
                     input logic [2:0] pend, input logic ovr);
    vectors++;
    if (GRANT_CPU !== gc || GRANT_REF !== gr || REF_PENDING !== pend || REF_OVERRUN !== ovr)
    begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got cpu=%b ref=%b pend=%0d ovr=%b, want cpu=%b ref=%b pend=%0d ovr=%b",
               name, cycle, GRANT_CPU, GRANT_REF, REF_PENDING, REF_OVERRUN, gc, gr, pend, ovr);
    end
  endtask

  // Inputs are applied before the next edge; outputs are sampled 1 ns after it.
  task automatic cyc(input logic cs, input logic as, input logic acc, input logic rd);
    CS_n = cs; AS_n = as; ACC_DONE = acc; REF_DONE = rd;
    @(posedge CLK);
    #1;
    cycle++;
    ACC_DONE = 1'b0; REF_DONE = 1'b0;
  endtask

  task automatic run_to(input int n, input logic cs, input logic as);
    while (cycle < n) cyc(cs, as, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    RST_n = 1'b0; CS_n = 1'b1; AS_n = 1'b1; ACC_DONE = 1'b0; REF_DONE = 1'b0;
    repeat (2) @(posedge CLK);
    #2 RST_n = 1'b1;
    cycle = 0;
    chk("reset_state", 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic add(input logic cs, input logic as, input logic acc, input logic rd,
                     input logic gc, input logic gr, input logic [2:0] pend, input logic ovr);
    vec_t v;
    v.cs_n = cs; v.as_n = as; v.acc = acc; v.rdone = rd;
    v.gc = gc; v.gr = gr; v.pend = pend; v.ovr = ovr;
    tbl.push_back(v);
  endtask

  initial begin
    RST_n = 1'b1; CS_n = 1'b1; AS_n = 1'b1; ACC_DONE = 1'b0; REF_DONE = 1'b0;
    #1;

    // Table: entry n drives edge n. CPU strobe from edge 2, ACC_DONE at 10,
    // strobe held 5 more cycles, then refreshes and stray DONE pulses.
    //   cs    as    acc   rd    gc    gr    pend  ovr
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0); // 1
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0); // 2
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0); // 3
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0); // 4
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0); // 5 grant k+3
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0); // 6
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0); // 7
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0); // 8 tick, no pre-empt
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0); // 9
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0); // 10 ACC_DONE drops grant
    for (int i = 11; i <= 15; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0); // 16 tick
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0); // 17
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0); // 18 back to idle
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0); // 19 refresh
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0); // 20 REF_DONE
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0); // 21
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0); // 22
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0); // 23 stray ACC_DONE
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0); // 24 stray REF_DONE + tick
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0); // 25

    do_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i].cs_n, tbl[i].as_n, tbl[i].acc, tbl[i].rdone);
      chk("table", tbl[i].gc, tbl[i].gr, tbl[i].pend, tbl[i].ovr);
    end

    // Idle bus, no DONE pulses: credits every 8 cycles, overrun on the fifth tick.
    do_reset();
    for (int c = 1; c <= 40; c++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("idle_accum", 1'b0, (c >= 9), ((c / 8) > 4) ? 3'd4 : 3'(c / 8), (c >= 40));
    end

    // Credits 2 with a CPU request pending: CPU wins, and is not pre-empted.
    do_reset();
    run_to(19, 1'b1, 1'b1);
    run_to(24, 1'b0, 1'b0);
    chk("c2_ref_held", 1'b0, 1'b1, 3'd3, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("c2_ref_done", 1'b0, 1'b0, 3'd2, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("c2_cpu_first", 1'b1, 1'b0, 3'd2, 1'b0);
    run_to(40, 1'b0, 1'b0);
    chk("urgent_waits", 1'b1, 1'b0, 3'd4, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("urgent_cpu_end", 1'b0, 1'b0, 3'd4, 1'b0);

    // Credits 4: tick and REF_DONE cancel, refresh beats CPU, then overrun.
    do_reset();
    run_to(32, 1'b1, 1'b1);
    chk("c4_full", 1'b0, 1'b1, 3'd4, 1'b0);
    run_to(39, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("tick_and_done", 1'b0, 1'b0, 3'd4, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("c4_ref_first", 1'b0, 1'b1, 3'd4, 1'b0);
    run_to(47, 1'b0, 1'b0);
    chk("pre_overrun", 1'b0, 1'b1, 3'd4, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("overrun_set", 1'b0, 1'b1, 3'd4, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("c3_after_done", 1'b0, 1'b0, 3'd3, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("c3_cpu_first", 1'b1, 1'b0, 3'd3, 1'b1);

    // Asynchronous reset mid-refresh with 3 credits owed.
    do_reset();
    run_to(25, 1'b1, 1'b1);
    chk("pre_async_rst", 1'b0, 1'b1, 3'd3, 1'b0);
    RST_n = 1'b0;
    #1;
    chk("async_rst", 1'b0, 1'b0, 3'd0, 1'b0);
    repeat (2) @(posedge CLK);
    #2 RST_n = 1'b1;
    cycle = 0;
    for (int c = 1; c <= 8; c++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("post_rst_tick", 1'b0, 1'b0, (c == 8) ? 3'd1 : 3'd0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
